// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: breathe-cycle duty sequencer for a 4-LED PWM stage; define PWM_FADE_LOOP_EN to breathe continuously until stop
module pwm_fade_ctrl #(
  parameter int PERIOD       = 100,
  parameter int STEP         = 5,
  parameter int STEP_PERIODS = 4,
  parameter int HOLD_PERIODS = 50,
  parameter int CW           = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] duty,
  output logic [3:0]    led
);
  localparam int SW = $clog2(STEP_PERIODS + 1);
  localparam int HW = $clog2(HOLD_PERIODS + 1);
  typedef enum logic [1:0] {IDLE, UP, HOLD, DOWN} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q, cnt_d, duty_q;
  logic [SW-1:0] step_q;
  logic [HW-1:0] hold_q;
  logic          busy_q, done_q, stop_pend_q;
  logic          pb, abort, step_due;
  logic [CW:0]   up_sum;
  assign pb       = cnt_q == CW'(PERIOD - 1);
  assign cnt_d    = pb ? '0 : cnt_q + CW'(1);
  assign abort    = pb && state_q != IDLE && (stop_pend_q || stop);
  assign step_due = step_q == SW'(STEP_PERIODS - 1);
  assign up_sum   = {1'b0, duty_q} + (CW+1)'(STEP);
  assign led      = {cnt_q < duty_q, cnt_q < (duty_q >> 1), cnt_q < (duty_q >> 2), cnt_q < (duty_q >> 3)};
  assign busy     = busy_q;
  assign done     = done_q;
  assign duty     = duty_q;
  // free-running period counter; its wrap cycle is the period boundary
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // breathe sequencer: duty and state only move at the period boundary, except leaving IDLE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      duty_q      <= '0;
      step_q      <= '0;
      hold_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && stop) stop_pend_q <= 1'b1;
      if (abort) begin
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        duty_q      <= '0;
        step_q      <= '0;
        hold_q      <= '0;
        stop_pend_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start && !stop) begin
            state_q <= UP;
            busy_q  <= 1'b1;
            step_q  <= '0;
          end
          UP: if (pb) begin
            if (step_due) begin
              step_q <= '0;
              if (up_sum >= (CW+1)'(PERIOD)) begin
                duty_q  <= CW'(PERIOD);
                state_q <= HOLD;
                hold_q  <= '0;
              end else duty_q <= up_sum[CW-1:0];
            end else step_q <= step_q + SW'(1);
          end
          HOLD: if (pb) begin
            if (hold_q == HW'(HOLD_PERIODS - 1)) begin
              state_q <= DOWN;
              step_q  <= '0;
              hold_q  <= '0;
            end else hold_q <= hold_q + HW'(1);
          end
          DOWN: if (pb) begin
            if (step_due) begin
              step_q <= '0;
              if ({1'b0, duty_q} <= (CW+1)'(STEP)) begin
                duty_q  <= '0;
                done_q  <= 1'b1;
`ifdef PWM_FADE_LOOP_EN
                state_q <= UP;
`else
                state_q <= IDLE;
                busy_q  <= 1'b0;
`endif
              end else duty_q <= duty_q - CW'(STEP);
            end else step_q <= step_q + SW'(1);
          end
          default: state_q <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl: scoreboard bench; stimulus queues expected output events, a monitor pops them on every output change
module tb_pwm_fade_ctrl;
  logic       clk = 1'b0, rst_n = 1'b1, start = 1'b0, stop = 1'b0;
  logic       busy, done;
  logic [7:0] duty;
  logic [3:0] led;
  int         cyc;
  int         n_chk = 0, n_pass = 0;
  typedef struct {int c; int d; int b; int dn;} ev_t;
  ev_t        q[$];
  logic [9:0] prev_obs = '0;

  pwm_fade_ctrl #(.PERIOD(10), .STEP(5), .STEP_PERIODS(1), .HOLD_PERIODS(2), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .busy(busy), .done(done), .duty(duty), .led(led)
  );

  always #5 clk = ~clk;

  // cycle index: number of rising edges since reset release, so cnt == cyc % 10
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
  endtask

  task automatic exp_ev(input int c, input int d, input int b, input int dn);
    ev_t e;
    e.c = c; e.d = d; e.b = b; e.dn = dn;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // monitor: any change of {duty,busy,done} must match the next queued event
  always @(negedge clk) begin
    logic [9:0] obs;
    ev_t e;
    if (rst_n) begin
      obs = {duty, busy, done};
      if (obs != prev_obs) begin
        if (q.size() == 0) chk("unexpected_event", cyc, -1);
        else begin
          e = q.pop_front();
          chk("ev_cyc", cyc, e.c);
          chk("ev_duty", int'(duty), e.d);
          chk("ev_busy", int'(busy), e.b);
          chk("ev_done", int'(done), e.dn);
        end
        prev_obs = obs;
      end
    end
  end

  initial begin
    int d, c;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_duty", int'(duty), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_led", int'(led), 0);
    rst_n = 1'b1;
    exp_ev(13, 0, 1, 0);
    exp_ev(20, 5, 1, 0);
    exp_ev(30, 10, 1, 0);
    exp_ev(60, 5, 1, 0);
`ifdef PWM_FADE_LOOP_EN
    exp_ev(70, 0, 1, 1);
    exp_ev(71, 0, 1, 0);
`else
    exp_ev(70, 0, 0, 1);
    exp_ev(71, 0, 0, 0);
    exp_ev(73, 0, 1, 0);
`endif
    exp_ev(80, 5, 1, 0);
    exp_ev(90, 10, 1, 0);
    exp_ev(100, 0, 0, 0);
    wait_cyc(5);
    chk("idle_duty", int'(duty), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_led", int'(led), 0);
    wait_cyc(12);
    start = 1'b1;
    wait_cyc(13);
    start = 1'b0;
    for (int k = 20; k < 40; k++) begin
      wait_cyc(k);
      d = (k < 30) ? 5 : 10;
      c = k % 10;
      chk("led_pattern", int'(led), {29'd0, c < d, c < d / 2, c < d / 4, c < d / 8});
      start = (k == 22);
    end
    start = 1'b0;
    wait_cyc(72);
    start = 1'b1;
    wait_cyc(73);
    start = 1'b0;
    wait_cyc(93);
    stop = 1'b1;
    wait_cyc(94);
    stop = 1'b0;
    wait_cyc(102);
    start = 1'b1;
    stop  = 1'b1;
    wait_cyc(103);
    start = 1'b0;
    stop  = 1'b0;
    wait_cyc(104);
    stop = 1'b1;
    wait_cyc(105);
    stop = 1'b0;
    wait_cyc(130);
    chk("pending_events", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
